// File: rtl/gpu_pkg.sv
// Instruction-stream definitions shared by the controller and the blocks that
// execute its instructions.
package gpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_SMA       = 4'd1,
        OP_LOADI     = 4'd2,
        OP_LOAD      = 4'd3,
        OP_SENDL     = 4'd4,
        OP_WRITE     = 4'd5,
        OP_WRITEB    = 4'd6,
        OP_LOADB     = 4'd7,
        OP_OR        = 4'd8,
        OP_SENDITERS = 4'd9
    } isa_t;

    // Field positions within an MSB-first [0:31] instruction word.
    localparam int OP_MSB  = 0;
    localparam int OP_LSB  = 3;
    localparam int RA_MSB  = 4;
    localparam int RA_LSB  = 7;
    localparam int IMM_MSB = 8;
    localparam int IMM_LSB = 23;
    localparam int RB_MSB  = 24;
    localparam int RB_LSB  = 27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD1,
        ST_RD2,
        ST_CAPTURE
    } dispatch_state_t;

endpackage

// File: rtl/load_ramp.sv
// Produces base + i*diff for every FMA lane i, wrapping modulo 2^W.
module load_ramp #(
    parameter int W         = 16,
    parameter int FMA_COUNT = 2
) (
    input  logic [W-1:0]           base,
    input  logic [W-1:0]           diff,
    output logic [FMA_COUNT*W-1:0] ramp
);

    always_comb begin
        for (int i = 0; i < FMA_COUNT; i++) begin
            ramp[i*W +: W] = base + W'(i) * diff;
        end
    end

endmodule

// File: rtl/memory_dispatch.sv
// Memory-side executor for the data-movement opcodes: owns the line buffer,
// drives the data-cache BRAM port and strobes operands into the FMA array.
module memory_dispatch
    import gpu_pkg::*;
#(
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int PRIVATE_REG_WIDTH = 16,
    parameter int DATA_CACHE_WIDTH  = 16,
    parameter int DATA_CACHE_DEPTH  = 4096,
    parameter int FMA_COUNT         = 2
) (
    input  logic                                   clk_in,
    input  logic                                   rst_n_in,
    input  logic [0:INSTRUCTION_WIDTH-1]           instr_in,
    input  logic [PRIVATE_REG_WIDTH-1:0]           reg_a_in,
    input  logic [PRIVATE_REG_WIDTH-1:0]           reg_b_in,
    input  logic [PRIVATE_REG_WIDTH-1:0]           reg_c_in,
    input  logic                                   instr_valid_in,
    output logic                                   ready_out,
    output logic                                   dropped_out,
    output logic                                   cache_en_out,
    output logic                                   cache_we_out,
    output logic [$clog2(DATA_CACHE_DEPTH)-1:0]    cache_addr_out,
    output logic [3*FMA_COUNT*DATA_CACHE_WIDTH-1:0] cache_din_out,
    input  logic [3*FMA_COUNT*DATA_CACHE_WIDTH-1:0] cache_dout_in,
    output logic [FMA_COUNT*DATA_CACHE_WIDTH-1:0]  fma_a_out,
    output logic [FMA_COUNT*DATA_CACHE_WIDTH-1:0]  fma_b_out,
    output logic [FMA_COUNT*DATA_CACHE_WIDTH-1:0]  fma_c_out,
    output logic                                   fma_replace_c_out,
    output logic                                   fma_valid_out,
    output logic                                   fma_write_out
);

    localparam int W     = DATA_CACHE_WIDTH;
    localparam int AW    = $clog2(DATA_CACHE_DEPTH);
    localparam int WORDS = 3 * FMA_COUNT;
    localparam int LW    = WORDS * W;

    dispatch_state_t state, state_next;
    isa_t                    op;
    logic [3:0]              ra, rb;
    logic [15:0]             imm;
    logic                    accept;
    logic [LW-1:0]           line_buf, line_next, fma_src;
    logic [FMA_COUNT*W-1:0]  ramp;
    logic [AW-1:0]           addr_reg;
    logic                    pend_writeb, pend_replace, pend_valid;
    logic                    fma_load, replace_next, valid_next;
    logic                    unused_ok;

    assign op     = isa_t'(instr_in[OP_MSB:OP_LSB]);
    assign ra     = instr_in[RA_MSB:RA_LSB];
    assign imm    = instr_in[IMM_MSB:IMM_LSB];
    assign rb     = instr_in[RB_MSB:RB_LSB];
    assign unused_ok = ^{reg_a_in, reg_c_in, instr_in[RB_LSB+1:INSTRUCTION_WIDTH-1]};

    assign ready_out = (state == ST_IDLE);
    assign accept    = instr_valid_in & ready_out;

    // addr_reg is the single address register behind the BRAM port.
    assign cache_addr_out = addr_reg;

    load_ramp #(.W(W), .FMA_COUNT(FMA_COUNT)) u_load_ramp (
        .base (W'(reg_b_in)),
        .diff (W'(imm)),
        .ramp (ramp)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= ST_IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (accept && (op == OP_SMA || op == OP_WRITEB)) state_next = ST_RD1;
            ST_RD1:     state_next = ST_RD2;
            ST_RD2:     state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        line_next = line_buf;
        if (accept && op == OP_LOADI) begin
            for (int w = 0; w < WORDS; w++) begin
                if (int'(ra) == w) line_next[w*W +: W] = W'(imm);
            end
        end else if (accept && op == OP_LOAD) begin
            for (int i = 0; i < FMA_COUNT; i++) begin
                for (int s = 0; s < 3; s++) begin
                    if (int'(ra) == s) line_next[(3*i+s)*W +: W] = ramp[i*W +: W];
                end
            end
        end else if (state == ST_CAPTURE && !pend_writeb) begin
            line_next = cache_dout_in;
        end
    end

    // WRITE sources the FMA operands from line_buf, WRITEB from the captured read.
    always_comb begin
        fma_load     = (accept && op == OP_WRITE) || (state == ST_CAPTURE && pend_writeb);
        fma_src      = (state == ST_CAPTURE) ? cache_dout_in : line_buf;
        replace_next = (state == ST_CAPTURE) ? pend_replace : |ra;
        valid_next   = (state == ST_CAPTURE) ? pend_valid : |rb;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            line_buf          <= '0;
            addr_reg          <= '0;
            dropped_out       <= 1'b0;
            cache_en_out      <= 1'b0;
            cache_we_out      <= 1'b0;
            cache_din_out     <= '0;
            fma_a_out         <= '0;
            fma_b_out         <= '0;
            fma_c_out         <= '0;
            fma_replace_c_out <= 1'b0;
            fma_valid_out     <= 1'b0;
            fma_write_out     <= 1'b0;
            pend_writeb       <= 1'b0;
            pend_replace      <= 1'b0;
            pend_valid        <= 1'b0;
        end else begin
            cache_en_out  <= 1'b0;
            cache_we_out  <= 1'b0;
            fma_write_out <= 1'b0;
            line_buf      <= line_next;
            if (instr_valid_in && !ready_out) dropped_out <= 1'b1;
            if (accept) begin
                case (op)
                    OP_SMA: begin
                        addr_reg     <= imm[AW-1:0];
                        cache_en_out <= 1'b1;
                        pend_writeb  <= 1'b0;
                    end
                    OP_WRITEB: begin
                        addr_reg     <= imm[AW-1:0];
                        cache_en_out <= 1'b1;
                        pend_writeb  <= 1'b1;
                        pend_replace <= |ra;
                        pend_valid   <= |rb;
                    end
                    OP_SENDL: begin
                        addr_reg      <= imm[AW-1:0];
                        cache_en_out  <= 1'b1;
                        cache_we_out  <= 1'b1;
                        cache_din_out <= line_buf;
                    end
                    default: ;
                endcase
            end
            if (fma_load) begin
                for (int i = 0; i < FMA_COUNT; i++) begin
                    fma_a_out[i*W +: W] <= fma_src[(3*i)*W +: W];
                    fma_b_out[i*W +: W] <= fma_src[(3*i+1)*W +: W];
                    fma_c_out[i*W +: W] <= fma_src[(3*i+2)*W +: W];
                end
                fma_replace_c_out <= replace_next;
                fma_valid_out     <= valid_next;
                fma_write_out     <= 1'b1;
            end
        end
    end

endmodule
